// File: rtl/matmul_pkg.sv
// Shared definitions for the tiled matrix-multiply sequencing logic.
//   - sched_state_e : scheduler FSM states
//   - *_DEF         : default matrix and block dimensions
//   - STEP_W        : width of the linear job-index status output
//   - step_index()  : linear job index i*NB*NB + j*NB + k
package matmul_pkg;

  localparam int MATRIX_SIZE_DEF = 128;
  localparam int BLOCK_SIZE_DEF  = 64;
  localparam int STEP_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_WB_ISSUE = 3'd3,
    ST_WB_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } sched_state_e;

  function automatic logic [STEP_W-1:0] step_index(input int i, input int j,
                                                   input int k, input int nb);
    int lin;
    lin = i * nb * nb + j * nb + k;
    return lin[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/matrix_block_scheduler_if.sv
// Command/status bundle between the block scheduler and its surroundings.
//   start, abort          : run control into the scheduler
//   blk_start / blk_done  : block-MAC engine launch pulse and completion pulse
//   blk_i/j/k, blk_accumulate : job coordinates, valid with blk_start/wb_start
//   wb_start / wb_done    : write-back launch pulse and completion pulse
//   current_step, computation_active, done, timeout_err : status
//
// Handshake semantics: every launch (blk_start, wb_start) is a single-cycle
// pulse and every completion (blk_done, wb_done) is a single-cycle pulse.
// There is no back-pressure; a completion is only honoured while the
// scheduler is waiting for it, and is otherwise dropped.
//
// master : the scheduler itself; slave : the engine/host side.
interface matrix_block_scheduler_if #(
  parameter int IDXW = 1
) ();

  logic                          start;
  logic                          abort;
  logic                          blk_start;
  logic                          blk_done;
  logic [IDXW-1:0]               blk_i;
  logic [IDXW-1:0]               blk_j;
  logic [IDXW-1:0]               blk_k;
  logic                          blk_accumulate;
  logic                          wb_start;
  logic                          wb_done;
  logic [matmul_pkg::STEP_W-1:0] current_step;
  logic                          computation_active;
  logic                          done;
  logic                          timeout_err;

  modport master (
    input  start, abort, blk_done, wb_done,
    output blk_start, blk_i, blk_j, blk_k, blk_accumulate, wb_start,
           current_step, computation_active, done, timeout_err
  );

  modport slave (
    output start, abort, blk_done, wb_done,
    input  blk_start, blk_i, blk_j, blk_k, blk_accumulate, wb_start,
           current_step, computation_active, done, timeout_err
  );

endinterface

// File: rtl/block_index_counter.sv
// Nested block-index counter: k is the innermost index, then j, then i.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : zero all three indices (highest priority)
//   inc_k_i       : advance k within the current (i, j) tile
//   next_tile_i   : k <= 0 and advance j, carrying into i on wrap
//   i_o, j_o, k_o : current indices (hold when no command is given)
//   last_k_o      : k is at NB-1
//   last_tile_o   : (i, j) is at (NB-1, NB-1)
module block_index_counter #(
  parameter int NB   = 2,
  parameter int IDXW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            inc_k_i,
  input  logic            next_tile_i,
  output logic [IDXW-1:0] i_o,
  output logic [IDXW-1:0] j_o,
  output logic [IDXW-1:0] k_o,
  output logic            last_k_o,
  output logic            last_tile_o
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NB - 1);

  logic [IDXW-1:0] i_q, i_d;
  logic [IDXW-1:0] j_q, j_d;
  logic [IDXW-1:0] k_q, k_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (inc_k_i) begin
      k_d = k_q + 1'b1;
    end else if (next_tile_i) begin
      k_d = '0;
      if (j_q == LAST) begin
        j_d = '0;
        i_d = i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o         = i_q;
  assign j_o         = j_q;
  assign k_o         = k_q;
  assign last_k_o    = (k_q == LAST);
  assign last_tile_o = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/matrix_block_scheduler.sv
// Sequencing controller for the tiled matrix-multiply datapath. Walks the
// (NB)^3 block jobs in i, j, k order, launching the block-MAC engine for each
// job and the write-back unit once per (i, j) tile, with a per-wait timeout.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : command/status bundle (master side)
//   dbg_state_o : current FSM state, for observation only
module matrix_block_scheduler
  import matmul_pkg::*;
#(
  parameter int MATRIX_SIZE    = MATRIX_SIZE_DEF,
  parameter int BLOCK_SIZE     = BLOCK_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matrix_block_scheduler_if.master bus,
  output sched_state_e             dbg_state_o
);

  localparam int NB    = MATRIX_SIZE / BLOCK_SIZE;
  localparam int IDXW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds (cycles already waited); the cycle that would make it
  // reach TIMEOUT_CYCLES is the one that gives up.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  sched_state_e     state_q;
  logic             blk_start_q;
  logic             wb_start_q;
  logic             done_q;
  logic             active_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q;

  logic [IDXW-1:0]  i_w, j_w, k_w;
  logic             last_k_w, last_tile_w;
  logic             clear_w, inc_k_w, next_tile_w, tmo_hit_w;

  assign tmo_hit_w   = (tmo_q == TMO_LAST);
  // Index updates must never happen on an aborted cycle so that the job
  // coordinates stay frozen at the point the run was cancelled.
  assign clear_w     = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign inc_k_w     = (state_q == ST_WAIT) && bus.blk_done && !bus.abort && !last_k_w;
  assign next_tile_w = (state_q == ST_WB_WAIT) && bus.wb_done && !bus.abort && !last_tile_w;

  block_index_counter #(
    .NB   (NB),
    .IDXW (IDXW)
  ) u_idx (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_w),
    .inc_k_i     (inc_k_w),
    .next_tile_i (next_tile_w),
    .i_o         (i_w),
    .j_o         (j_w),
    .k_o         (k_w),
    .last_k_o    (last_k_w),
    .last_tile_o (last_tile_w)
  );

  // Pulse outputs are registered together with the state they belong to, so
  // blk_start is high exactly while in ISSUE, wb_start in WB_ISSUE, done in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blk_start_q <= 1'b0;
      wb_start_q  <= 1'b0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      blk_start_q <= 1'b0;
      wb_start_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            err_q       <= 1'b0;
            state_q     <= ST_ISSUE;
            blk_start_q <= 1'b1;
            active_q    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          tmo_q   <= '0;
        end
        ST_WAIT: begin
          // A completion arriving on the last allowed cycle still counts.
          if (bus.blk_done) begin
            if (last_k_w) begin
              state_q    <= ST_WB_ISSUE;
              wb_start_q <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              blk_start_q <= 1'b1;
            end
          end else if (tmo_hit_w) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b1;
            active_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WB_ISSUE: begin
          state_q <= ST_WB_WAIT;
          tmo_q   <= '0;
        end
        ST_WB_WAIT: begin
          if (bus.wb_done) begin
            if (last_tile_w) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              active_q <= 1'b0;
            end else begin
              state_q     <= ST_ISSUE;
              blk_start_q <= 1'b1;
            end
          end else if (tmo_hit_w) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b1;
            active_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
      // Abort overrides whatever the case above decided, including a timeout.
      if (bus.abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        blk_start_q <= 1'b0;
        wb_start_q  <= 1'b0;
        done_q      <= 1'b0;
        active_q    <= 1'b0;
        err_q       <= err_q;
      end
    end
  end

  assign bus.blk_start          = blk_start_q;
  assign bus.wb_start           = wb_start_q;
  assign bus.done               = done_q;
  assign bus.computation_active = active_q;
  assign bus.timeout_err        = err_q;
  assign bus.blk_i              = i_w;
  assign bus.blk_j              = j_w;
  assign bus.blk_k              = k_w;
  assign bus.blk_accumulate     = (k_w != '0);
  assign bus.current_step       = step_index(32'(i_w), 32'(j_w), 32'(k_w), NB);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_matrix_block_scheduler.sv
// Self-checking bench for matrix_block_scheduler with default matrix sizes
// and a shortened timeout. The engine and write-back responders are modelled
// cycle by cycle inside run_product(); expected job order, tile order and
// completion cycle come from nested loops and latency sums.
module tb_matrix_block_scheduler;
  import matmul_pkg::*;

  localparam int NB         = MATRIX_SIZE_DEF / BLOCK_SIZE_DEF;
  localparam int IDXW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int TB_TIMEOUT = 200;
  localparam int RUN_BUDGET = 1000;
  localparam int REC_W      = 3 * IDXW + 1 + STEP_W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  sched_state_e dbg_state;

  always #5 clk = ~clk;

  matrix_block_scheduler_if #(.IDXW(IDXW)) bus ();

  matrix_block_scheduler #(
    .MATRIX_SIZE    (MATRIX_SIZE_DEF),
    .BLOCK_SIZE     (BLOCK_SIZE_DEF),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0]    exp_q[$];
  logic [REC_W-1:0]    obs_q[$];
  logic [2*IDXW-1:0]   exp_wb_q[$];
  logic [2*IDXW-1:0]   obs_wb_q[$];
  int asserts = 0;
  int fails   = 0;
  int done_cyc, done_cnt, err_cyc, abort_cyc, sum_lat;
  logic act_c1, err_c1, act_after_abort, act_at_done;

  // Expected job records {i, j, k, accumulate, step} and tiles {i, j}.
  function automatic void build_model();
    exp_q.delete();
    exp_wb_q.delete();
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++) begin
        for (int k = 0; k < NB; k++)
          exp_q.push_back({IDXW'(i), IDXW'(j), IDXW'(k), (k != 0),
                           STEP_W'(i * NB * NB + j * NB + k)});
        exp_wb_q.push_back({IDXW'(i), IDXW'(j)});
      end
  endfunction

  function automatic int seq_mismatch();
    int bad = 0;
    if (obs_q.size() != exp_q.size()) bad++;
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++)
      if (obs_q[n] !== exp_q[n]) bad++;
    return bad;
  endfunction

  function automatic int wb_mismatch();
    int bad = 0;
    if (obs_wb_q.size() != exp_wb_q.size()) bad++;
    for (int n = 0; n < exp_wb_q.size() && n < obs_wb_q.size(); n++)
      if (obs_wb_q[n] !== exp_wb_q[n]) bad++;
    return bad;
  endfunction

  function automatic int fixed_done(input int l, input int w);
    return 1 + NB * NB * NB * (l + 1) + NB * NB * (w + 1);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Cycle 1 is the cycle after the
  // edge that samples start. Inputs set in cycle c are sampled at the edge
  // ending cycle c; outputs are observed mid-cycle.
  task automatic run_product(input int lat_lo, input int lat_hi,
                             input int w_lo, input int w_hi,
                             input int abort_job, input bit noise,
                             input bit rst_in_wb);
    int blk_due, wb_due, rst_due, nblk, tail, lat;
    blk_due = -1; wb_due = -1; rst_due = -1; nblk = 0; tail = -1;
    obs_q.delete();
    obs_wb_q.delete();
    done_cyc = -1; done_cnt = 0; err_cyc = -1; abort_cyc = -1; sum_lat = 0;
    act_c1 = 1'b0; err_c1 = 1'b1; act_after_abort = 1'b1; act_at_done = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= RUN_BUDGET; cyc++) begin
      bus.start    = 1'b0;
      bus.blk_done = 1'b0;
      bus.wb_done  = 1'b0;
      bus.abort    = 1'b0;
      if (cyc == 1) begin
        act_c1 = bus.computation_active;
        err_c1 = bus.timeout_err;
      end
      if (abort_cyc > 0 && cyc == abort_cyc + 1) act_after_abort = bus.computation_active;
      if (bus.blk_start) begin
        obs_q.push_back({bus.blk_i, bus.blk_j, bus.blk_k, bus.blk_accumulate, bus.current_step});
        nblk++;
        lat = int'($urandom_range(lat_hi, lat_lo));
        blk_due = cyc + lat;
        sum_lat += lat + 1;
        if (noise) bus.blk_done = 1'b1;  // spurious completion during ISSUE
      end
      if (bus.wb_start) begin
        obs_wb_q.push_back({bus.blk_i, bus.blk_j});
        lat = int'($urandom_range(w_hi, w_lo));
        wb_due = cyc + lat;
        sum_lat += lat + 1;
        if (rst_in_wb && rst_due < 0) rst_due = cyc + 1;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = cyc;
          act_at_done = bus.computation_active;
        end
      end
      if (bus.timeout_err && err_cyc < 0) err_cyc = cyc;
      if (cyc == blk_due) begin
        bus.blk_done = 1'b1;
        if (nblk == abort_job) begin
          bus.abort = 1'b1;
          abort_cyc = cyc;
        end
      end
      if (cyc == wb_due) bus.wb_done = 1'b1;
      if (noise && done_cyc < 0 && (cyc % 9) == 0) bus.start = 1'b1;
      if (cyc == rst_due) begin
        rst_n = 1'b0;
        break;
      end
      if (tail < 0 && (done_cyc > 0 || err_cyc > 0 || abort_cyc > 0)) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.blk_done = 1'b0;
    bus.wb_done  = 1'b0;
    bus.abort    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.blk_done = 1'b0; bus.wb_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({bus.blk_start, bus.wb_start, bus.done, bus.computation_active, bus.timeout_err,
         bus.blk_i, bus.blk_j, bus.blk_k, bus.blk_accumulate, bus.current_step} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got blk_start=%b wb_start=%b done=%b active=%b err=%b ijk=%0d%0d%0d acc=%b step=%0d, required all 0",
               bus.blk_start, bus.wb_start, bus.done, bus.computation_active, bus.timeout_err,
               bus.blk_i, bus.blk_j, bus.blk_k, bus.blk_accumulate, bus.current_step);
    end
    asserts++;
    if (dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    asserts++;
    if ({bus.blk_start, bus.computation_active, bus.done} !== 3'b000 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL idle_after_reset: got state=%0d active=%b, required IDLE and 0",
               dbg_state, bus.computation_active);
    end
  endtask

  task automatic test_nominal();
    run_product(10, 10, 3, 3, 0, 1'b0, 1'b0);
    asserts++;
    if (seq_mismatch() !== 0) begin
      fails++;
      $display("FAIL nominal_seq: %0d job records differ (%0d jobs seen), required 0", seq_mismatch(), obs_q.size());
    end
    asserts++;
    if (wb_mismatch() !== 0) begin
      fails++;
      $display("FAIL nominal_wb: %0d tile records differ (%0d seen), required 0", wb_mismatch(), obs_wb_q.size());
    end
    asserts++;
    if (done_cyc !== fixed_done(10, 3)) begin
      fails++;
      $display("FAIL nominal_done_cycle: got %0d, required %0d", done_cyc, fixed_done(10, 3));
    end
    asserts++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL nominal_done_count: got %0d, required 1", done_cnt);
    end
    asserts++;
    if (act_c1 !== 1'b1 || act_at_done !== 1'b0) begin
      fails++;
      $display("FAIL nominal_active: got %b at cycle 1 and %b at done, required 1 and 0", act_c1, act_at_done);
    end
    asserts++;
    if (dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL nominal_end_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_zero_gap();
    run_product(1, 1, 1, 1, 0, 1'b0, 1'b0);
    asserts++;
    if (seq_mismatch() !== 0 || wb_mismatch() !== 0) begin
      fails++;
      $display("FAIL zero_gap_seq: %0d jobs and %0d tiles seen, %0d/%0d differ, required 0",
               obs_q.size(), obs_wb_q.size(), seq_mismatch(), wb_mismatch());
    end
    asserts++;
    if (done_cyc !== fixed_done(1, 1) || done_cnt !== 1) begin
      fails++;
      $display("FAIL zero_gap_done: got cycle %0d count %0d, required cycle %0d count 1",
               done_cyc, done_cnt, fixed_done(1, 1));
    end
  endtask

  task automatic test_random_latency();
    for (int it = 0; it < 4; it++) begin
      run_product(1, 12, 1, 6, 0, 1'b0, 1'b0);
      asserts++;
      if (seq_mismatch() !== 0 || wb_mismatch() !== 0) begin
        fails++;
        $display("FAIL random_seq%0d: %0d/%0d records differ, required 0", it, seq_mismatch(), wb_mismatch());
      end
      asserts++;
      if (done_cyc !== 1 + sum_lat || done_cnt !== 1) begin
        fails++;
        $display("FAIL random_done%0d: got cycle %0d count %0d, required cycle %0d count 1",
                 it, done_cyc, done_cnt, 1 + sum_lat);
      end
    end
  endtask

  task automatic test_timeout();
    run_product(100000, 100000, 1, 1, 0, 1'b0, 1'b0);
    asserts++;
    if (err_cyc !== TB_TIMEOUT + 2) begin
      fails++;
      $display("FAIL timeout_cycle: got %0d, required %0d", err_cyc, TB_TIMEOUT + 2);
    end
    asserts++;
    if (done_cnt !== 0 || obs_q.size() !== 1) begin
      fails++;
      $display("FAIL timeout_no_done: got done count %0d jobs %0d, required 0 and 1", done_cnt, obs_q.size());
    end
    asserts++;
    if (dbg_state !== ST_IDLE || bus.computation_active !== 1'b0 || bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_after: got state=%0d active=%b err=%b, required IDLE, 0, 1",
               dbg_state, bus.computation_active, bus.timeout_err);
    end
    run_product(2, 5, 1, 3, 0, 1'b0, 1'b0);
    asserts++;
    if (err_c1 !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got err=%b after new start, required 0", err_c1);
    end
    asserts++;
    if (done_cyc !== 1 + sum_lat || seq_mismatch() !== 0) begin
      fails++;
      $display("FAIL timeout_rerun: got done cycle %0d, %0d job diffs, required %0d and 0",
               done_cyc, seq_mismatch(), 1 + sum_lat);
    end
  endtask

  task automatic test_abort();
    // start and abort together in IDLE: start is dropped
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    asserts++;
    if (dbg_state !== ST_IDLE || bus.computation_active !== 1'b0 || bus.blk_start !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle_start: got state=%0d active=%b blk_start=%b, required IDLE, 0, 0",
               dbg_state, bus.computation_active, bus.blk_start);
    end
    @(negedge clk);
    // abort coincident with the 3rd blk_done
    run_product(10, 10, 3, 3, 3, 1'b0, 1'b0);
    asserts++;
    if (obs_q.size() !== 3 || obs_wb_q.size() !== 1 || done_cnt !== 0) begin
      fails++;
      $display("FAIL abort_pulses: got %0d jobs %0d tiles %0d done, required 3, 1, 0",
               obs_q.size(), obs_wb_q.size(), done_cnt);
    end
    asserts++;
    if (obs_q.size() < 3 || obs_q[2] !== exp_q[2]) begin
      fails++;
      $display("FAIL abort_third_job: got %0d jobs, third record mismatched, required %h", obs_q.size(), exp_q[2]);
    end
    asserts++;
    if (act_after_abort !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL abort_active: got active=%b state=%0d, required 0 and IDLE", act_after_abort, dbg_state);
    end
    run_product(10, 10, 3, 3, 0, 1'b0, 1'b0);
    asserts++;
    if (seq_mismatch() !== 0 || done_cyc !== fixed_done(10, 3)) begin
      fails++;
      $display("FAIL abort_restart: got %0d job diffs, done cycle %0d, required 0 and %0d",
               seq_mismatch(), done_cyc, fixed_done(10, 3));
    end
  endtask

  task automatic test_ignored_inputs();
    run_product(10, 10, 3, 3, 0, 1'b1, 1'b0);
    asserts++;
    if (seq_mismatch() !== 0 || wb_mismatch() !== 0) begin
      fails++;
      $display("FAIL noise_seq: %0d/%0d records differ (%0d jobs), required 0",
               seq_mismatch(), wb_mismatch(), obs_q.size());
    end
    asserts++;
    if (done_cyc !== fixed_done(10, 3) || done_cnt !== 1) begin
      fails++;
      $display("FAIL noise_done: got cycle %0d count %0d, required cycle %0d count 1",
               done_cyc, done_cnt, fixed_done(10, 3));
    end
  endtask

  task automatic test_async_reset();
    run_product(10, 10, 3, 3, 0, 1'b0, 1'b1);
    #1;
    asserts++;
    if ({bus.blk_start, bus.wb_start, bus.done, bus.computation_active, bus.timeout_err,
         bus.blk_i, bus.blk_j, bus.blk_k, bus.blk_accumulate, bus.current_step} !== '0) begin
      fails++;
      $display("FAIL async_reset_outputs: got active=%b ijk=%0d%0d%0d acc=%b step=%0d, required all 0",
               bus.computation_active, bus.blk_i, bus.blk_j, bus.blk_k, bus.blk_accumulate, bus.current_step);
    end
    asserts++;
    if (dbg_state !== ST_IDLE || done_cnt !== 0) begin
      fails++;
      $display("FAIL async_reset_state: got state=%0d done count %0d, required IDLE and 0", dbg_state, done_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_product(10, 10, 3, 3, 0, 1'b0, 1'b0);
    asserts++;
    if (seq_mismatch() !== 0 || wb_mismatch() !== 0 || done_cyc !== fixed_done(10, 3)) begin
      fails++;
      $display("FAIL async_reset_rerun: %0d/%0d diffs, done cycle %0d, required 0/0 and %0d",
               seq_mismatch(), wb_mismatch(), done_cyc, fixed_done(10, 3));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    build_model();
    test_reset();
    test_nominal();
    test_zero_gap();
    test_random_latency();
    test_timeout();
    test_abort();
    test_ignored_inputs();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
